// File: rtl/i2c_req_arbiter_if.sv
// Requester-fabric and master-command bundle for the shared I2C master arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface i2c_req_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          req_rw;
  logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
  logic [NUM_REQ*DATA_LEN-1:0] req_wdata;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          done;
  logic [DATA_LEN-1:0]         resp_rdata;
  logic [1:0]                  resp_err;
  logic                        mst_start;
  logic                        mst_rw;
  logic [ADDR_LEN-1:0]         mst_addr;
  logic [DATA_LEN-1:0]         mst_wdata;
  logic                        mst_abort;
  logic                        mst_done;
  logic                        mst_nack;
  logic [DATA_LEN-1:0]         mst_rdata;

  modport slave (
    input  req, req_rw, req_addr, req_wdata, mst_done, mst_nack, mst_rdata,
    output gnt, done, resp_rdata, resp_err, mst_start, mst_rw, mst_addr, mst_wdata,
           mst_abort
  );

  modport master (
    output req, req_rw, req_addr, req_wdata, mst_done, mst_nack, mst_rdata,
    input  gnt, done, resp_rdata, resp_err, mst_start, mst_rw, mst_addr, mst_wdata,
           mst_abort
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master among NUM_REQ requesters and
// sequences a single-byte transaction per grant, with a timeout abort.
//
// state     | meaning
// S_IDLE    | no transaction; arbitrate among pending requests
// S_WAIT    | master busy; wait for mst_done or timeout
// S_RELEASE | done/abort pulse cycle; req not sampled
module i2c_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8,
  parameter int TIMEOUT  = 1000,
  parameter int TO_W     = 10
) (
  input logic              clk_i,
  input logic              rst_n_i,
  i2c_req_arbiter_if.slave bus_if
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [TO_W-1:0]     timer_q, timer_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic                rw_q, rw_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic [ADDR_LEN-1:0] addr_a  [NUM_REQ];
  logic [DATA_LEN-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_a[g]  = bus_if.req_addr[g*ADDR_LEN +: ADDR_LEN];
    assign wdata_a[g] = bus_if.req_wdata[g*DATA_LEN +: DATA_LEN];
  end

  // Scan from the farthest candidate down so the nearest one after last_q wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (bus_if.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    start_d = 1'b0;
    abort_d = 1'b0;
    last_d  = last_q;
    win_d   = win_q;
    timer_d = timer_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = ONE_HOT0 << win_idx;
          start_d = 1'b1;
          win_d   = win_idx;
          rw_d    = bus_if.req_rw[win_idx];
          addr_d  = addr_a[win_idx];
          wdata_d = wdata_a[win_idx];
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TO_W'(1);
        // Completion takes precedence over a coincident timeout.
        if (bus_if.mst_done) begin
          done_d  = gnt_q;
          rdata_d = bus_if.mst_rdata;
          err_d   = {1'b0, bus_if.mst_nack};
          gnt_d   = '0;
          last_d  = win_q;
          state_d = S_RELEASE;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          done_d  = gnt_q;
          err_d   = 2'b10;
          gnt_d   = '0;
          last_d  = win_q;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      timer_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.gnt        = gnt_q;
  assign bus_if.done       = done_q;
  assign bus_if.resp_rdata = rdata_q;
  assign bus_if.resp_err   = err_q;
  assign bus_if.mst_start  = start_q;
  assign bus_if.mst_rw     = rw_q;
  assign bus_if.mst_addr   = addr_q;
  assign bus_if.mst_wdata  = wdata_q;
  assign bus_if.mst_abort  = abort_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_i2c_req_arbiter;
  localparam int N   = 4;
  localparam int AL  = 7;
  localparam int DL  = 8;
  localparam int TO  = 100;
  localparam int TOW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  i2c_req_arbiter_if #(.NUM_REQ(N), .ADDR_LEN(AL), .DATA_LEN(DL)) bus ();

  i2c_req_arbiter #(
    .NUM_REQ(N), .ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT(TO), .TO_W(TOW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = r >> ((last + k) % N);
      if (s[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transaction-level reference: who owns the master, for how long, and what it reports.
  logic [N-1:0]  e_gnt, e_done;
  logic          e_start, e_abort, e_rw;
  logic [AL-1:0] e_addr;
  logic [DL-1:0] e_wdata, e_rdata;
  logic [1:0]    e_err;
  bit            m_busy, m_cool;
  int            m_last, m_w, m_cnt, m_next;

  always_comb m_next = pick(bus.req, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt <= '0; e_done <= '0; e_start <= 1'b0; e_abort <= 1'b0;
      e_rw <= 1'b0; e_addr <= '0; e_wdata <= '0; e_rdata <= '0; e_err <= 2'b00;
      m_busy <= 1'b0; m_cool <= 1'b0; m_last <= N - 1; m_w <= 0; m_cnt <= 0;
    end else begin
      e_start <= 1'b0;
      e_done  <= '0;
      e_abort <= 1'b0;
      if (m_cool) begin
        m_cool <= 1'b0;
      end else if (m_busy) begin
        if (bus.mst_done) begin
          e_done <= e_gnt; e_rdata <= bus.mst_rdata; e_err <= {1'b0, bus.mst_nack};
          e_gnt <= '0; m_last <= m_w; m_busy <= 1'b0; m_cool <= 1'b1;
        end else if (m_cnt == TO - 1) begin
          e_abort <= 1'b1; e_done <= e_gnt; e_err <= 2'b10;
          e_gnt <= '0; m_last <= m_w; m_busy <= 1'b0; m_cool <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (m_next >= 0) begin
        m_w     <= m_next;
        e_gnt   <= N'(1) << m_next;
        e_start <= 1'b1;
        e_rw    <= bus.req_rw[m_next];
        e_addr  <= AL'(bus.req_addr >> (m_next * AL));
        e_wdata <= DL'(bus.req_wdata >> (m_next * DL));
        m_cnt   <= 0;
        m_busy  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", bus.gnt, e_gnt);
      check("done", bus.done, e_done);
      check("mst_start", bus.mst_start, e_start);
      check("mst_abort", bus.mst_abort, e_abort);
      if (e_done != '0) begin
        check("resp_err", bus.resp_err, e_err);
        check("resp_rdata", bus.resp_rdata, e_rdata);
      end
      if (e_gnt != '0) begin
        check("mst_rw", bus.mst_rw, e_rw);
        check("mst_addr", bus.mst_addr, e_addr);
        check("mst_wdata", bus.mst_wdata, e_wdata);
      end
    end
  end

  int c_start = 0, c_done = 0, c_abort = 0, c_gnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mst_start) c_start++;
      if (bus.done != '0) c_done++;
      if (bus.mst_abort) c_abort++;
      if (bus.gnt != '0) c_gnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [AL-1:0] a,
                         input logic [DL-1:0] d);
    bus.req_rw[i] = rw;
    bus.req_addr[i*AL +: AL] = a;
    bus.req_wdata[i*DL +: DL] = d;
  endtask

  task automatic wait_start(output int idx);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.mst_start && n < 200);
    check("start_seen", bus.mst_start, 1'b1);
    idx = oh2i(bus.gnt);
  endtask

  task automatic pulse_done(input logic nack, input logic [DL-1:0] rd);
    bus.mst_done = 1'b1; bus.mst_nack = nack; bus.mst_rdata = rd;
    step(1);
    bus.mst_done = 1'b0; bus.mst_nack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, s0, d0, a0, g0, cnt;
    int order [5];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mst_done = 1'b0; bus.mst_nack = 1'b0; bus.mst_rdata = '0;

    // reset state
    step(2);
    chk_en = 1'b1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_start", bus.mst_start, 0);
    check("rst_abort", bus.mst_abort, 0);
    check("rst_err", bus.resp_err, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_addr", bus.mst_addr, 0);
    check("rst_wdata", bus.mst_wdata, 0);
    check("rst_rw", bus.mst_rw, 0);
    rst_n = 1'b1;
    step(2);

    // single write, 91-cycle transaction; fields changed after grant are ignored
    set_req(0, 1'b0, 7'h50, 8'hA5);
    bus.req = 4'b0001;
    g0 = c_gnt; s0 = c_start; d0 = c_done;
    wait_start(idx);
    check("w_idx", idx, 0);
    check("w_addr", bus.mst_addr, 7'h50);
    check("w_wdata", bus.mst_wdata, 8'hA5);
    check("w_rw", bus.mst_rw, 0);
    bus.req = '0;
    set_req(0, 1'b1, 7'h11, 8'h00);
    step(90);
    pulse_done(1'b0, 8'hEE);
    check("w_done", bus.done, 4'b0001);
    check("w_err", bus.resp_err, 0);
    check("w_rdata", bus.resp_rdata, 8'hEE);
    step(3);
    check("w_gnt_cycles", c_gnt - g0, 91);
    check("w_starts", c_start - s0, 1);
    check("w_dones", c_done - d0, 1);

    // read with NACK on requester 2
    set_req(2, 1'b1, 7'h21, 8'h00);
    bus.req = 4'b0100;
    wait_start(idx);
    check("r_idx", idx, 2);
    check("r_rw", bus.mst_rw, 1);
    bus.req = '0;
    step(29);
    pulse_done(1'b1, 8'h3C);
    check("r_done", bus.done, 4'b0100);
    check("r_err", bus.resp_err, 2'b01);
    check("r_rdata", bus.resp_rdata, 8'h3C);
    step(3);

    // stray mst_done while idle
    d0 = c_done;
    pulse_done(1'b0, 8'h99);
    step(3);
    check("idle_dones", c_done - d0, 0);
    check("idle_rdata", bus.resp_rdata, 8'h3C);

    // timeout on requester 1
    set_req(1, 1'b0, 7'h2A, 8'h5A);
    bus.req = 4'b0010;
    a0 = c_abort;
    wait_start(idx);
    check("to_idx", idx, 1);
    bus.req = '0;
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!bus.mst_abort && cnt < 2 * TO);
    check("to_dist", cnt, 100);
    check("to_done", bus.done, 4'b0010);
    check("to_err", bus.resp_err, 2'b10);
    check("to_rdata", bus.resp_rdata, 8'h3C);
    step(1);
    check("to_abort_width", bus.mst_abort, 0);
    check("to_done_width", bus.done, 0);
    step(2);
    check("to_aborts", c_abort - a0, 1);
    check("to_idle_gnt", bus.gnt, 0);

    // mst_done coincides with the timeout edge
    set_req(3, 1'b1, 7'h33, 8'h00);
    bus.req = 4'b1000;
    a0 = c_abort;
    wait_start(idx);
    check("col_idx", idx, 3);
    bus.req = '0;
    step(TO - 1);
    pulse_done(1'b0, 8'h77);
    check("col_done", bus.done, 4'b1000);
    check("col_err", bus.resp_err, 2'b00);
    check("col_rdata", bus.resp_rdata, 8'h77);
    check("col_abort", bus.mst_abort, 0);
    step(3);
    check("col_aborts", c_abort - a0, 0);

    // reset mid-WAIT after last grant was requester 0
    set_req(0, 1'b0, 7'h10, 8'h01);
    bus.req = 4'b0001;
    wait_start(idx);
    bus.req = '0;
    step(4);
    pulse_done(1'b0, 8'h00);
    step(3);
    set_req(2, 1'b0, 7'h12, 8'h02);
    bus.req = 4'b0100;
    wait_start(idx);
    check("rw_idx", idx, 2);
    step(5);
    rst_n = 1'b0;
    #1;
    check("rw_gnt", bus.gnt, 0);
    check("rw_done", bus.done, 0);
    check("rw_start", bus.mst_start, 0);
    check("rw_addr", bus.mst_addr, 0);
    step(2);
    set_req(1, 1'b1, 7'h41, 8'h00);
    bus.req = 4'b0011;
    rst_n = 1'b1;
    wait_start(idx);
    check("rw_prio", idx, 0);
    step(2);
    pulse_done(1'b0, 8'h10);
    bus.req = '0;
    step(3);
    bus.req = 4'b0010;
    wait_start(idx);
    check("rw_req1", idx, 1);
    step(2);
    pulse_done(1'b0, 8'h20);
    bus.req = '0;
    step(3);

    // fairness from a fresh reset with all requesters held
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, i[0], AL'(8'h60 + i), DL'(8'hC0 + i));
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start(order[i]);
      step(9);
      pulse_done(1'b0, DL'(i));
      if (i == 4) bus.req = '0;
    end
    step(3);
    for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), order[i], exp_order[i]);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and transaction sequencer that shares the single I2C master (master FSM plus SCL generator) among NUM_REQ on-chip requesters. It grants one requester at a time and latches that requester's address, direction and write byte. It then launches one single-byte transaction on the master, waits for completion, NACK or timeout, and returns read data and status to the granted requester. It sits between the requester fabric and the master FSM's command inputs.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_LEN, 7: slave address width.
- DATA_LEN, 8: data byte width.
- TIMEOUT, 1000: cycles allowed in WAIT before abort, 2..2^TO_W-1.
- TO_W, 10: timeout counter width.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request, level.
- req_rw  in  NUM_REQ  per-requester direction, 1 = read, 0 = write.
- req_addr  in  NUM_REQ*ADDR_LEN  per-requester slave address; requester i occupies bits [i*ADDR_LEN +: ADDR_LEN].
- req_wdata  in  NUM_REQ*DATA_LEN  per-requester write byte, packed the same way.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- resp_rdata  out  DATA_LEN  read byte, valid while done is high.
- resp_err  out  2  00 = ok, 01 = NACK, 10 = timeout; valid while done is high.
- mst_start  out  1  one-cycle start pulse to the master FSM.
- mst_rw, mst_addr, mst_wdata  out  1 / ADDR_LEN / DATA_LEN  command fields to the master; stable from the mst_start cycle until the next grant.
- mst_abort  out  1  one-cycle pulse that forces the master to Stop/Idle.
- mst_done  in  1  one-cycle pulse: master finished the transaction and its Stop.
- mst_nack  in  1  qualified by mst_done; 1 = slave NACKed address or data.
- mst_rdata  in  DATA_LEN  master's received byte, qualified by mst_done.

## Operation
- States: IDLE, WAIT, RELEASE. Encoding is free.
- Round-robin pointer last_gnt has reset value NUM_REQ-1, so requester 0 has first priority.
- Priority order is last_gnt+1, last_gnt+2, … modulo NUM_REQ.
- IDLE, no req: stay in IDLE; all outputs idle.
- IDLE, req != 0: winner w is the first set bit in priority order. On that edge:
  - gnt <= onehot(w) and mst_start <= 1.
  - mst_rw, mst_addr and mst_wdata are loaded from slice w.
  - timer <= 0 and state <= WAIT.
- WAIT, each cycle:
  - mst_start <= 0 and timer <= timer+1.
  - If mst_done = 1:
    - done <= onehot(w).
    - resp_rdata <= mst_rdata, captured for both reads and writes.
    - resp_err <= {1'b0, mst_nack}.
    - gnt <= 0, last_gnt <= w, state <= RELEASE.
  - Else, if timer == TIMEOUT-1:
    - mst_abort <= 1 and done <= onehot(w).
    - resp_err <= 10; resp_rdata holds its previous value.
    - gnt <= 0, last_gnt <= w, state <= RELEASE.
  - If mst_done and the timeout coincide, mst_done wins and mst_abort is not asserted.
- RELEASE: done <= 0, mst_abort <= 0, state <= IDLE. req is not sampled in RELEASE. Requesters must drop req during the done cycle.
- req deasserted mid-transaction: ignored; the transaction completes and done still pulses.
- Changes to req_* fields after the grant edge are ignored.
- mst_done outside WAIT is ignored and never produces done.
- A requester that holds req after its done gets lower priority than all other pending requesters on the next arbitration.

## Timing
- Reset values:
  - State IDLE, gnt = 0, done = 0.
  - mst_start = 0, mst_abort = 0.
  - resp_rdata = 0, resp_err = 00.
  - mst_rw = 0, mst_addr = 0, mst_wdata = 0.
  - timer = 0, last_gnt = NUM_REQ-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency: req sampled high at edge k gives gnt and mst_start high from edge k through edge k+1. mst_start is exactly one cycle wide.
- Completion: mst_done high at edge m gives done high for cycle m..m+1 and gnt low from m.
- Timeout: mst_abort and done rise at the edge where timer == TIMEOUT-1, i.e. TIMEOUT cycles after entering WAIT.
- Back-to-back throughput: the earliest next grant is the edge after RELEASE, so the minimum gap between two mst_start pulses is mst_done latency + 2 cycles.
- Reset mid-transaction clears everything immediately. No mst_abort pulse is generated; the master is reset by the same rst_n.

## Test plan
- Single write: req = 0001, addr 7'h50, wdata 8'hA5, rw 0; mst_done after 90 cycles with nack 0. Required: gnt = 0001 for 91 cycles, one mst_start, done = 0001 for 1 cycle, resp_err = 00.
- Read with NACK: req[2] high, rw 1; mst_done with nack 1 and mst_rdata 8'h3C. Required: done = 0100, resp_err = 01, resp_rdata = 8'h3C.
- Fairness: req = 1111 held continuously, each mst_done 10 cycles after mst_start. Required grant order 0, 1, 2, 3, 0 with no requester granted twice in a row.
- Timeout: TIMEOUT = 20, mst_done never asserted. Required: mst_abort and done pulse exactly 20 cycles after mst_start, resp_err = 10, then return to IDLE.
- Timeout collision: mst_done asserted on the same cycle timer == TIMEOUT-1. Required: resp_err = 00 or 01 per mst_nack, and mst_abort stays 0.
- Reset mid-WAIT: assert rst_n low 5 cycles after mst_start. Required: gnt, done and mst_start all 0 immediately. After release with req = 0010, the grant goes to requester 1 because last_gnt was reset.
